serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b - bin, one bit per clock, LSB first.
- Built around a single full-subtractor cell (xor/and/or difference-borrow logic) plus a borrow flip-flop; the inverse companion to the team's full-adder cell.
- Sits wherever area matters more than latency; start/ready handshake in, one-cycle done pulse out.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when start && ready at a rising edge.
- a  input  WIDTH  minuend; sampled on acceptance only.
- b  input  WIDTH  subtrahend; sampled on acceptance only.
- bin  input  1  borrow-in; sampled on acceptance only.
- ready  output  1  high only in IDLE.
- busy  output  1  high in SHIFT and DONE.
- diff  output  WIDTH  result, (a - b - bin) mod 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b + bin (unsigned).
- done  output  1  one-cycle pulse; diff/bout valid from this cycle on.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, ready=1, busy=0, done=0, diff=0, bout=0, all internal shift registers, bit counter and borrow flop = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - On start && ready: load a_sr<=a, b_sr<=b, brw<=bin, cnt<=0; go to SHIFT.
  - start low: stay in IDLE.
- SHIFT, each cycle:
  - d = a_sr[0] ^ b_sr[0] ^ brw.
  - brw_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw).
  - r_sr <= {d, r_sr[WIDTH-1:1]}; a_sr, b_sr shift right by 1; cnt++.
  - When cnt == WIDTH-1: diff <= {d, r_sr[WIDTH-1:1]}, bout <= brw_next; go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE unconditionally.
- Latency:
  - Acceptance edge E; done is high in the cycle following edge E+WIDTH.
  - Next start accepted no earlier than edge E+WIDTH+2.
  - Throughput: one operation per WIDTH+2 cycles.
- diff/bout change only on the edge entering DONE. They hold their value otherwise, including across IDLE and through the next operation until its completion.
- start while busy (SHIFT or DONE) is ignored and not queued. Operand changes while busy have no effect.
- start held high continuously: a new operation is accepted on every IDLE cycle (back-to-back with the 1-cycle IDLE gap).
- rst_n asserted mid-operation: immediate abort, all outputs to reset values, no done pulse. After release, the block is in IDLE, ready=1.
- Arithmetic is unsigned modulo 2^WIDTH. Wrap-around is reported only through bout; there is no overflow flag.

Test Plan:
- Reset then WIDTH=8, a=0x5A, b=0x23, bin=0, start 1 cycle -> done pulse 8 cycles after acceptance edge, diff=0x37, bout=0, ready back high next cycle.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0. Then a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0.
- Pulse start again and change a/b during SHIFT -> no second acceptance, result reflects originally sampled operands, exactly one done pulse.
- start held high over 3 operations (0x10-0x01, 0x20-0x02, 0x30-0x03) -> done pulses spaced WIDTH+2=10 cycles apart, diffs 0x0F, 0x1E, 0x2D.
- Assert rst_n low 4 cycles into SHIFT -> diff=0, bout=0, done never pulses, ready=1 immediately. A fresh op 0x09-0x04 afterwards -> diff=0x05.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: start/ready request side, done-pulse result side.
// Latency and backpressure are set by the attached subtractor; the interface itself is combinational wiring.
// A requester drives start only while ready is high; anything asserted otherwise is simply not seen.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             done;

    modport master (
        output start, a, b, bin,
        input  ready, busy, diff, bout, done
    );

    modport slave (
        input  start, a, b, bin,
        output ready, busy, diff, bout, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial diff = a - b - bin, LSB first, through one full-subtractor cell and a borrow flop.
// Latency: done pulses in the cycle after edge E+WIDTH (E = acceptance edge); one op per WIDTH+2 cycles.
// Backpressure: ready is high only in IDLE; start while busy is dropped, never queued.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   io
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_r_sr;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_brw;
    logic             r_bout;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic             w_d;
    logic             w_brw_next;
    logic [WIDTH-1:0] w_r_next;

    // Full-subtractor cell on the current LSBs and the running borrow.
    assign w_d        = r_a_sr[0] ^ r_b_sr[0] ^ r_brw;
    assign w_brw_next = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_brw);
    assign w_r_next   = {w_d, r_r_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_r_sr  <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_brw   <= 1'b0;
            r_bout  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (io.start && r_ready) begin
                        r_a_sr  <= io.a;
                        r_b_sr  <= io.b;
                        r_brw   <= io.bin;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_r_sr <= w_r_next;
                    r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_brw  <= w_brw_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_diff  <= w_r_next;
                        r_bout  <= w_brw_next;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io.ready = r_ready;
    assign io.busy  = r_busy;
    assign io.diff  = r_diff;
    assign io.bout  = r_bout;
    assign io.done  = r_done;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor with hand-computed results, latency and handshake checks.
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    serial_subtractor_if #(.WIDTH(WIDTH)) io ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge with ready high; returns at the negedge after done, checking ready came back.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic binv,
                          input logic [7:0] exp_d, input logic exp_b);
        int n;
        check({tag, "_rdy_pre"}, 32'(io.ready), 32'd1);
        io.start = 1'b1;
        io.a     = av;
        io.b     = bv;
        io.bin   = binv;
        @(posedge clk);
        #1 io.start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!io.done && n < WIDTH + 6);
        check({tag, "_done"}, 32'(io.done), 32'd1);
        check({tag, "_lat"}, 32'(n), 32'(WIDTH + 1));
        check({tag, "_diff"}, 32'(io.diff), 32'(exp_d));
        check({tag, "_bout"}, 32'(io.bout), 32'(exp_b));
        @(negedge clk);
        check({tag, "_rdy_post"}, 32'(io.ready), 32'd1);
        check({tag, "_done_1cyc"}, 32'(io.done), 32'd0);
    endtask

    logic [7:0] bb_a   [3];
    logic [7:0] bb_b   [3];
    logic [7:0] bb_exp [3];

    initial begin
        int k;
        int j;
        int t;
        int pulses;
        int done_t [3];

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        io.start = 1'b0;
        io.a     = '0;
        io.b     = '0;
        io.bin   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(io.ready), 32'd1);
        check("rst_busy",  32'(io.busy),  32'd0);
        check("rst_done",  32'(io.done),  32'd0);
        check("rst_diff",  32'(io.diff),  32'd0);
        check("rst_bout",  32'(io.bout),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("basic",   8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
        run_op("wrap1",   8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        run_op("wrapbin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        run_op("equal",   8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
        run_op("bin_eq",  8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

        // Start while busy with operands changing mid-flight.
        io.start = 1'b1;
        io.a     = 8'h40;
        io.b     = 8'h11;
        io.bin   = 1'b0;
        @(posedge clk);
        #1 io.start = 1'b0;
        pulses = 0;
        for (int i = 1; i <= WIDTH + 6; i++) begin
            @(negedge clk);
            if (i == 2) begin
                check("busy_in_shift", 32'(io.busy), 32'd1);
                check("rdy_in_shift",  32'(io.ready), 32'd0);
                io.start = 1'b1;
                io.a     = 8'hFF;
                io.b     = 8'h00;
                io.bin   = 1'b1;
            end
            if (i == 5) io.start = 1'b0;
            if (io.done) begin
                pulses++;
                check("busy_diff", 32'(io.diff), 32'h2F);
                check("busy_bout", 32'(io.bout), 32'd0);
            end
        end
        check("busy_pulses", 32'(pulses), 32'd1);
        check("busy_idle", 32'(io.ready), 32'd1);

        // start held high across three back-to-back operations.
        bb_a[0] = 8'h10; bb_b[0] = 8'h01; bb_exp[0] = 8'h0F;
        bb_a[1] = 8'h20; bb_b[1] = 8'h02; bb_exp[1] = 8'h1E;
        bb_a[2] = 8'h30; bb_b[2] = 8'h03; bb_exp[2] = 8'h2D;
        io.start = 1'b1;
        io.a     = bb_a[0];
        io.b     = bb_b[0];
        io.bin   = 1'b0;
        k = 1;
        j = 0;
        t = 0;
        while (j < 3 && t < 60) begin
            @(negedge clk);
            t++;
            if (io.done) begin
                done_t[j] = t;
                check($sformatf("b2b_diff%0d", j), 32'(io.diff), 32'(bb_exp[j]));
                check($sformatf("b2b_bout%0d", j), 32'(io.bout), 32'd0);
                j++;
            end
            if (io.ready) begin
                if (k < 3) begin
                    io.a = bb_a[k];
                    io.b = bb_b[k];
                    k++;
                end else begin
                    io.start = 1'b0;
                end
            end
        end
        io.start = 1'b0;
        check("b2b_count", 32'(j), 32'd3);
        if (j == 3) begin
            check("b2b_gap01", 32'(done_t[1] - done_t[0]), 32'(WIDTH + 2));
            check("b2b_gap12", 32'(done_t[2] - done_t[1]), 32'(WIDTH + 2));
        end
        @(negedge clk);

        // Asynchronous abort partway through SHIFT.
        check("abort_rdy_pre", 32'(io.ready), 32'd1);
        io.start = 1'b1;
        io.a     = 8'h5A;
        io.b     = 8'h23;
        io.bin   = 1'b0;
        @(posedge clk);
        #1 io.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_diff",  32'(io.diff),  32'd0);
        check("abort_bout",  32'(io.bout),  32'd0);
        check("abort_ready", 32'(io.ready), 32'd1);
        check("abort_busy",  32'(io.busy),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(negedge clk);
            if (io.done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        check("abort_idle",    32'(io.ready), 32'd1);
        run_op("post_abort", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (got timeout, expected summary)");
        $fatal(1);
    end
endmodule
